// File: rtl/cwt_scale_sched.sv
// Per-frame CWT scale scheduler: walks scales 0..J1-1, streams N spectrum/wavelet reads per scale, then waits for the IFFT result.
// Reads are issued 1 cycle ahead of mult_valid_o; a scale starts only when the IFFT is idle and the result store is free.
module cwt_scale_sched #(
  parameter int N       = 1024,
  parameter int J1      = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             frame_start_i,
  input  logic                             abort_i,
  input  logic                             ifft_idle_i,
  input  logic                             store_busy_i,
  input  logic                             ifft_done_i,
  output logic                             spec_rd_en_o,
  output logic [$clog2(N)-1:0]             spec_addr_o,
  output logic [$clog2(N)+$clog2(J1)-1:0]  wav_addr_o,
  output logic                             mult_valid_o,
  output logic                             mult_last_o,
  output logic [$clog2(J1)-1:0]            scale_o,
  output logic                             busy_o,
  output logic                             frame_done_o,
  output logic [1:0]                       err_o
);

  localparam int KW = $clog2(N);
  localparam int JW = $clog2(J1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IFFT,
    S_STREAM,
    S_WAIT_DONE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [1:0]      err_d;
  logic            k_last;

  assign k_last      = (k_q == KW'(N - 1));
  assign spec_addr_o = k_q;
  assign wav_addr_o  = {j_q, k_q};
  assign scale_o     = j_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      tcnt_q  <= '0;
      err_o   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      tcnt_q  <= tcnt_d;
      err_o   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    j_d          = j_q;
    k_d          = k_q;
    tcnt_d       = tcnt_q;
    err_d        = err_o;
    busy_o       = (state_q != S_IDLE);
    spec_rd_en_o = 1'b0;
    frame_done_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          err_d   = '0;
          j_d     = '0;
          state_d = S_WAIT_IFFT;
        end
      end
      S_WAIT_IFFT: begin
        if (ifft_idle_i && !store_busy_i) begin
          k_d     = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        spec_rd_en_o = 1'b1;
        k_d          = k_q + 1'b1;
        if (k_last) begin
          tcnt_d  = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        tcnt_d = tcnt_q + 1'b1;
        // A done arriving on the final allowed cycle still counts as on time.
        if (ifft_done_i) begin
          state_d = S_NEXT;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_d[0] = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_NEXT: begin
        if (j_q == JW'(J1 - 1)) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = S_WAIT_IFFT;
        end
      end
      S_DONE: begin
        frame_done_o = 1'b1;
        j_d          = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_start_i && (state_q != S_IDLE)) begin
      err_d[1] = 1'b1;
    end

    // Abort overrides everything; in IDLE it only suppresses a simultaneous start.
    if (abort_i) begin
      state_d = S_IDLE;
      err_d   = err_o;
      tcnt_d  = tcnt_q;
      j_d     = (state_q == S_IDLE) ? j_q : '0;
      k_d     = (state_q == S_IDLE) ? k_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mult_valid_o <= 1'b0;
      mult_last_o  <= 1'b0;
    end else if (abort_i) begin
      mult_valid_o <= 1'b0;
      mult_last_o  <= 1'b0;
    end else begin
      mult_valid_o <= spec_rd_en_o;
      mult_last_o  <= spec_rd_en_o && k_last;
    end
  end

endmodule

// File: tb/tb_cwt_scale_sched.sv
// Bench for cwt_scale_sched: directed corner frames plus randomized done delays and stalls, checked against a frame-level model.
module tb_cwt_scale_sched;
  localparam int N       = 8;
  localparam int J1      = 4;
  localparam int TIMEOUT = 16;
  localparam int KW      = $clog2(N);
  localparam int JW      = $clog2(J1);

  logic clk = 1'b0;
  logic rstn;
  logic frame_start, abort, ifft_idle, store_busy, ifft_done;
  logic spec_rd_en_o, mult_valid_o, mult_last_o, busy_o, frame_done_o;
  logic [KW-1:0]    spec_addr_o;
  logic [KW+JW-1:0] wav_addr_o;
  logic [JW-1:0]    scale_o;
  logic [1:0]       err_o;

  cwt_scale_sched #(.N(N), .J1(J1), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .frame_start_i(frame_start), .abort_i(abort), .ifft_idle_i(ifft_idle),
    .store_busy_i(store_busy), .ifft_done_i(ifft_done),
    .spec_rd_en_o(spec_rd_en_o), .spec_addr_o(spec_addr_o), .wav_addr_o(wav_addr_o),
    .mult_valid_o(mult_valid_o), .mult_last_o(mult_last_o), .scale_o(scale_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_cyc, done_cyc, done_n;
  int wav_q[$], spec_q[$], scl_q[$];
  int dly[J1];   // done delay per scale, counted in WAIT_DONE cycles; 0 withholds done
  int hold[J1];  // stall cycles imposed while the scale waits to start
  bit stall_sel;
  logic prv_rd = 1'b0, prv_last = 1'b0, prv_ab = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prv_rd   <= spec_rd_en_o;
    prv_last <= spec_rd_en_o && (spec_addr_o == KW'(N - 1));
    prv_ab   <= abort;
  end

  // Every read beat is logged; the multiplier side must echo reads one cycle later unless aborted.
  always @(negedge clk) begin
    if (rstn) begin
      chk("mult_valid", mult_valid_o, prv_rd && !prv_ab);
      chk("mult_last", mult_last_o, prv_last && !prv_ab);
      if (spec_rd_en_o) begin
        wav_q.push_back(int'(wav_addr_o));
        spec_q.push_back(int'(spec_addr_o));
        scl_q.push_back(int'(scale_o));
        chk("busy_stream", busy_o, 1);
      end
      if (frame_done_o) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  task automatic stall(input bit v);
    if (stall_sel) store_busy = v;
    else           ifft_idle  = !v;
  endtask

  task automatic set_all(input int d);
    for (int s = 0; s < J1; s++) begin
      dly[s]  = d;
      hold[s] = 0;
    end
  endtask

  task automatic check_beats();
    for (int i = 0; i < wav_q.size(); i++) begin
      chk("wav_addr", wav_q[i], i);
      chk("spec_addr", spec_q[i], i % N);
      chk("beat_scale", scl_q[i], i / N);
    end
  endtask

  task automatic wait_beat(input int k, input int s, output bit ok);
    int cnt = 0;
    while (!(spec_rd_en_o && spec_addr_o == KW'(k) && scale_o == JW'(s)) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    ok = spec_rd_en_o && spec_addr_o == KW'(k) && scale_o == JW'(s);
    if (!ok) chk("beat_wait", 0, 1);
  endtask

  // mode: 0 normal, 1 extra start during scale 0, 2 abort at k=5 of scale arg, 3 reset at k=3 of scale arg
  task automatic run_frame(input int mode, input int arg);
    int cnt;
    int exp_lat;
    bit ok;
    wav_q.delete(); spec_q.delete(); scl_q.delete();
    done_n = 0;
    exp_lat = 1;
    for (int s = 0; s < J1; s++) exp_lat += 1 + hold[s] + N + dly[s] + 1;

    frame_start = 1'b1;
    start_cyc = cyc;
    if (hold[0] > 0) stall(1'b1);
    @(negedge clk);
    frame_start = 1'b0;
    chk("err_clear", err_o, 0);
    chk("busy_start", busy_o, 1);
    if (hold[0] > 0) begin
      repeat (hold[0]) @(negedge clk);
      stall(1'b0);
    end

    if (mode == 1) begin
      wait_beat(3, 0, ok);
      if (!ok) return;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk("overrun_flag", err_o, 2);
    end

    for (int s = 0; s < J1; s++) begin
      if (mode == 2 && s == arg) begin
        wait_beat(5, s, ok);
        if (!ok) return;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_rd", spec_rd_en_o, 0);
        chk("abort_valid", mult_valid_o, 0);
        chk("abort_scale", scale_o, 0);
        chk("abort_beats", wav_q.size(), arg * N + 6);
        ifft_done = 1'b1;
        @(negedge clk);
        ifft_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_idle", busy_o, 0);
        chk("abort_no_done", done_n, 0);
        chk("abort_err", err_o, 0);
        check_beats();
        return;
      end
      if (mode == 3 && s == arg) begin
        wait_beat(3, s, ok);
        if (!ok) return;
        rstn = 1'b0;
        #1;
        chk("rst_outs", int'({spec_rd_en_o, spec_addr_o, wav_addr_o, mult_valid_o,
                              mult_last_o, scale_o, busy_o, frame_done_o, err_o}), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_idle", busy_o, 0);
        check_beats();
        return;
      end

      cnt = 0;
      while (!mult_last_o && cnt < 300) begin
        @(negedge clk);
        cnt++;
      end
      if (!mult_last_o) begin
        chk("last_wait", 0, 1);
        return;
      end

      if (dly[s] == 0) begin
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("to_busy_before", busy_o, 1);
        chk("to_err_before", err_o, 0);
        @(negedge clk);
        chk("to_busy_after", busy_o, 0);
        chk("to_err_after", err_o, 1);
        chk("to_rd", spec_rd_en_o, 0);
        repeat (3) @(negedge clk);
        chk("to_no_done", done_n, 0);
        chk("to_beats", wav_q.size(), (s + 1) * N);
        check_beats();
        return;
      end

      repeat (dly[s] - 1) @(negedge clk);
      ifft_done = 1'b1;
      if (s < J1 - 1 && hold[s+1] > 0) stall(1'b1);
      @(negedge clk);
      ifft_done = 1'b0;
      if (s < J1 - 1 && hold[s+1] > 0) begin
        repeat (hold[s+1] + 1) @(negedge clk);
        stall(1'b0);
      end
    end

    repeat (3) @(negedge clk);
    chk("done_count", done_n, 1);
    chk("frame_latency", done_cyc - start_cyc, exp_lat);
    chk("busy_end", busy_o, 0);
    chk("err_end", err_o, (mode == 1) ? 2 : 0);
    chk("scale_end", scale_o, 0);
    chk("beat_count", wav_q.size(), J1 * N);
    check_beats();
  endtask

  initial begin
    frame_start = 1'b0; abort = 1'b0; ifft_done = 1'b0;
    ifft_idle = 1'b1; store_busy = 1'b0; stall_sel = 1'b1;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("reset_rd", spec_rd_en_o, 0);
    chk("reset_addr", int'(wav_addr_o), 0);
    chk("reset_valid", int'({mult_valid_o, mult_last_o}), 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_scale", scale_o, 0);
    chk("reset_done", frame_done_o, 0);
    chk("reset_err", err_o, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    set_all(3); run_frame(0, 0);
    set_all(3); hold[1] = 20; run_frame(0, 0);
    set_all(3); dly[2] = 0; run_frame(0, 0);
    set_all(3); run_frame(0, 0);
    set_all(3); dly[0] = TIMEOUT; dly[3] = TIMEOUT; run_frame(0, 0);
    set_all(3); run_frame(1, 0);

    abort = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    abort = 1'b0; frame_start = 1'b0;
    chk("abort_start_busy", busy_o, 0);
    chk("abort_start_err", err_o, 2);
    repeat (2) @(negedge clk);
    chk("abort_start_idle", busy_o, 0);

    set_all(3); run_frame(2, 2);
    set_all(3); run_frame(3, 1);
    set_all(3); run_frame(0, 0);

    for (int f = 0; f < 6; f++) begin
      stall_sel = 1'($urandom_range(1, 0));
      for (int s = 0; s < J1; s++) begin
        dly[s]  = $urandom_range(TIMEOUT, 1);
        hold[s] = $urandom_range(6, 0);
      end
      run_frame(0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cwt_scale_sched.md
Name: cwt_scale_sched

Overview:
- Per-frame scheduler for the CWT datapath. On each new input spectrum it iterates scales j = 0..J1-1.
- For each scale it streams N spectrum samples and N daughter-wavelet coefficients into the multiply/IFFT chain, then waits for the IFFT frame to be written to the result store.
- It sits between the input FFT buffer, the wavelet ROM, the multiplier/IFFT and the CWT result store/readout.

Parameters:
- N, 1024, samples per frame; power of 2; KW = $clog2(N).
- J1, 64, number of scales; power of 2; JW = $clog2(J1).
- TIMEOUT, 4096, maximum cycles to wait for ifft_done_i per scale.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- frame_start_i  in  1  pulse: input spectrum buffer holds a new frame.
- abort_i  in  1  synchronous abort of the current frame.
- ifft_idle_i  in  1  IFFT can accept a new N-sample frame.
- store_busy_i  in  1  result store/readout is busy; do not start a scale.
- ifft_done_i  in  1  pulse: current scale's IFFT output has been fully stored.
- spec_rd_en_o  out  1  spectrum buffer read enable.
- spec_addr_o  out  KW  spectrum buffer address k.
- wav_addr_o  out  KW+JW  wavelet ROM address, equal to {j,k}.
- mult_valid_o  out  1  spectrum/wavelet data valid at the multiplier input.
- mult_last_o  out  1  marks sample N-1 of the scale, coincident with mult_valid_o.
- scale_o  out  JW  current scale index j.
- busy_o  out  1  a frame is in progress.
- frame_done_o  out  1  one-cycle pulse after the last scale completes.
- err_o  out  2  sticky flags: [1] overrun, [0] timeout.

Behaviour:
- Reset: every output is 0; state IDLE; j = 0, k = 0; timeout counter 0.
- Registers: state, j, k, timeout counter, mult_valid/last pipeline and err_o.
- Combinational outputs: spec_rd_en_o, spec_addr_o, wav_addr_o, busy_o.
- States are IDLE, WAIT_IFFT, STREAM, WAIT_DONE, NEXT and DONE.
- IDLE:
  - busy_o = 0.
  - frame_start_i: clear err_o, set j = 0, go to WAIT_IFFT.
- WAIT_IFFT:
  - busy_o = 1.
  - When ifft_idle_i = 1 and store_busy_i = 0 in the same cycle, set k = 0 and go to STREAM the next cycle.
- STREAM:
  - spec_rd_en_o = 1, spec_addr_o = k, wav_addr_o = j*N + k, for N consecutive cycles with no stall.
  - k increments each cycle. At k = N-1, go to WAIT_DONE and clear the timeout counter.
- Read latency:
  - mult_valid_o = spec_rd_en_o delayed exactly 1 cycle (1-cycle BRAM/ROM latency).
  - mult_last_o = (spec_rd_en_o and k = N-1) delayed 1 cycle.
  - The final mult_valid_o/mult_last_o therefore occurs in the first WAIT_DONE cycle.
- WAIT_DONE:
  - The timeout counter increments each cycle.
  - ifft_done_i = 1: go to NEXT.
  - Counter reaches TIMEOUT without ifft_done_i: set err_o[0] and go to IDLE; frame_done_o is not pulsed.
  - If ifft_done_i arrives in the same cycle the counter hits TIMEOUT, done wins.
- NEXT (1 cycle):
  - If j = J1-1, go to DONE.
  - Otherwise j increments and the state goes to WAIT_IFFT.
  - scale_o tracks j at all times and is never out of range.
- DONE (1 cycle): frame_done_o = 1, j = 0, go to IDLE.
- frame_start_i outside IDLE: ignored, err_o[1] set; the current frame continues unaffected.
- ifft_done_i outside WAIT_DONE: ignored, with no flag.
- abort_i (priority over all transitions):
  - Next state is IDLE; j and k cleared; the mult_valid/last pipeline is flushed to 0 on the same edge.
  - frame_done_o is not pulsed and err_o is unchanged.
  - abort_i in IDLE has no effect. abort_i together with frame_start_i in IDLE: abort wins and the frame does not start.
- Reset mid-frame: outputs return to reset values immediately (asynchronous); the frame is dropped.
- Frame latency, with ifft_idle_i high, store_busy_i low and done arriving D cycles into WAIT_DONE: per scale = 1 (WAIT_IFFT) + N + D + 1 (NEXT), plus 1 cycle for DONE.

Test Plan:
- N=8, J1=4, ifft_idle_i=1, store_busy_i=0, ifft_done_i 3 cycles into WAIT_DONE, frame_start_i pulse → 4 scales.
  - wav_addr_o sequence 0..31 in 4 bursts of 8 contiguous cycles.
  - mult_valid_o 8-cycle bursts lagging spec_rd_en_o by 1 cycle; mult_last_o on the 8th beat.
  - scale_o 0,1,2,3; frame_done_o exactly one pulse after scale 3; err_o = 0.
- store_busy_i held high 20 cycles during WAIT_IFFT of scale 1 → no spec_rd_en_o during the hold; streaming starts 1 cycle after store_busy_i falls; addresses 8..15.
- TIMEOUT=16, ifft_done_i withheld on scale 2 → err_o = 2'b01 after 16 WAIT_DONE cycles; state IDLE; no frame_done_o.
  - Next frame_start_i clears err_o and restarts at scale 0.
- frame_start_i pulsed mid-STREAM of scale 0 → err_o[1] = 1; frame completes normally with 4 scales and one frame_done_o.
- abort_i at k=5 of scale 2 → next cycle busy_o = 0, spec_rd_en_o = 0, mult_valid_o = 0, scale_o = 0; no frame_done_o.
  - A later ifft_done_i pulse is ignored.
- rstn low at k=3 of scale 1 → all outputs 0 immediately.
  - After release, a new frame_start_i runs a full 4-scale frame from scale 0.
